// File: rtl/bench_seq_pkg.sv
// Shared definitions for the sequencing controller: FSM state codes and the state type.
package bench_seq_pkg;

  // State codes. They are plain localparams because the state register must also
  // hold the illegal codes 5-7, which can be loaded through the scan chain.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_HOLD = ST_HOLD,
    S_DONE = ST_DONE,
    S_ERR  = ST_ERR
  } state_t;

endpackage

// File: rtl/bench_rr_pick.sv
// Round-robin picker: returns a one-hot vector for the first set request bit at or
// above ptr. The search moves upward and wraps past the top channel.
module bench_rr_pick #(
  parameter int NCH = 4,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt
);

  logic          found;
  logic [PW-1:0] idx;

  // Walk the channels from ptr upward. PW-bit arithmetic provides the wrap.
  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves one unassigned and infers a latch.
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = ptr + PW'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bench_seq_ctrl.sv
// Transfer sequencer. It grants one request channel round-robin, counts the transfer
// length down, stalls in HOLD while the granted request is low, and pulses DONE on
// completion. All registers also form a single scan chain.
module bench_seq_ctrl #(
  parameter int CW  = 5,
  parameter int NCH = 4
) (
  input  logic           CK,
  input  logic           RSTN,
  input  logic           CLR,
  input  logic           SE,
  input  logic           SI,
  output logic           SO,
  input  logic           START,
  input  logic           ABORT,
  input  logic [NCH-1:0] REQ,
  input  logic [CW-1:0]  LEN,
  output logic [NCH-1:0] GNT,
  output logic           BUSY,
  output logic           DONE,
  output logic           ERR,
  output logic [CW-1:0]  CNT
);

  import bench_seq_pkg::*;

  localparam int PW = $clog2(NCH);

  logic [2:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;

  logic [NCH-1:0] pick;
  logic [PW-1:0]  gnt_idx;
  logic           req_held;

  bench_rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // Index of the granted channel. The pointer advances past this channel on completion.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_q[i]) gnt_idx = PW'(i);
    end
  end

  assign req_held = |(REQ & gnt_q);

  // Next-state logic. Clear wins over scan, scan wins over abort, and abort wins over
  // the normal transitions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    if (CLR) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      gnt_d   = '0;
      ptr_d   = '0;
    end else if (SE) begin
      // Chain order {state, CNT, GNT, PTR}, shifted toward state[2] with SI entering at PTR[0].
      {state_d, cnt_d, gnt_d, ptr_d} = {state_q[1:0], cnt_q, gnt_q, ptr_q, SI};
    end else if (ABORT && (state_q == ST_RUN || state_q == ST_HOLD)) begin
      state_d = ST_ERR;
      gnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A zero length is an error even if no channel is requesting.
          if (START) begin
            if (LEN == '0) begin
              state_d = ST_ERR;
            end else if (|REQ) begin
              state_d = ST_RUN;
              gnt_d   = pick;
              cnt_d   = LEN;
            end
          end
        end
        ST_RUN: begin
          if (!req_held) begin
            state_d = ST_HOLD;
          end else if (cnt_q <= CW'(1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_HOLD: begin
          if (req_held) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = gnt_idx + PW'(1);
        end
        ST_ERR: begin
          // Sticky until CLR or reset.
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its pre-edge inputs.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign GNT  = gnt_q;
  assign CNT  = cnt_q;
  assign BUSY = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign DONE = (state_q == ST_DONE);
  assign ERR  = (state_q == ST_ERR);
  assign SO   = state_q[2];

endmodule

// File: tb/tb_bench_seq_ctrl.sv
// Scoreboard bench for bench_seq_ctrl. The driver pushes expected outputs as it applies
// stimulus. A monitor checks them on the falling edge and checks every DONE pulse
// against the grant queued when that transfer started.
module tb_bench_seq_ctrl;

  logic       CK, RSTN, CLR, SE, SI, START, ABORT;
  logic [3:0] REQ;
  logic [4:0] LEN;
  logic       SO, BUSY, DONE, ERR;
  logic [3:0] GNT;
  logic [4:0] CNT;

  bench_seq_ctrl #(.CW(5), .NCH(4)) dut (
    .CK(CK), .RSTN(RSTN), .CLR(CLR), .SE(SE), .SI(SI), .SO(SO),
    .START(START), .ABORT(ABORT), .REQ(REQ), .LEN(LEN),
    .GNT(GNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CNT(CNT)
  );

  typedef struct {
    string       name;
    logic [12:0] val;
    logic [12:0] mask;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] done_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  exp_t       mon_e;
  logic [3:0] mon_g;
  logic [13:0] pat;

  localparam logic [12:0] M_ALL   = 13'h1FFF;
  localparam logic [12:0] M_SO    = 13'h0001;
  localparam logic [12:0] M_NOCNT = 13'b1111_00000_1111;

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Pack outputs as {GNT, CNT, BUSY, DONE, ERR, SO}.
  function automatic logic [12:0] ov(input logic [3:0] g, input logic [4:0] c,
                                     input logic b, input logic d, input logic e, input logic so);
    return {g, c, b, d, e, so};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge CK);
    #1;
  endtask

  task automatic expect_v(input string nm, input logic [12:0] v, input logic [12:0] m);
    exp_t e;
    e.name = nm;
    e.val  = v;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  // Monitor: consumes one expectation per falling edge and checks each DONE pulse.
  initial begin
    forever begin
      @(negedge CK);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, 32'({GNT, CNT, BUSY, DONE, ERR, SO} & mon_e.mask),
              32'(mon_e.val & mon_e.mask));
      end
      if (DONE === 1'b1) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected done: got DONE=1 with GNT=%b, want no completion", GNT);
        end else begin
          mon_g = done_q.pop_front();
          check("done grant", 32'(GNT), 32'(mon_g));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    RSTN = 1'b1; CLR = 0; SE = 0; SI = 0; START = 0; ABORT = 0; REQ = '0; LEN = '0;
    pat = 14'b101_00000_0100_00;
    #1 RSTN = 1'b0;
    #1 check("reset state", 32'({GNT, CNT, BUSY, DONE, ERR, SO}), 32'(0));
    tick(); RSTN = 1'b1;
    expect_v("idle after reset", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);

    // First transfer from pointer 0: channel 1, count 3,2,1, then DONE.
    tick(); START = 1; REQ = 4'b0110; LEN = 5'd3; done_q.push_back(4'b0010);
    expect_v("t1 cnt3", ov(4'b0010, 5'd3, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t1 cnt2", ov(4'b0010, 5'd2, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t1 cnt1", ov(4'b0010, 5'd1, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t1 done", ov(4'b0010, 5'd0, 0, 1, 0, 0), M_ALL);
    tick(); expect_v("t1 idle", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);
    // START still high: immediate repeat from pointer 2 grants channel 2.
    tick(); done_q.push_back(4'b0100);
    expect_v("t2 cnt3", ov(4'b0100, 5'd3, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t2 cnt2", ov(4'b0100, 5'd2, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t2 cnt1", ov(4'b0100, 5'd1, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t2 done", ov(4'b0100, 5'd0, 0, 1, 0, 0), M_ALL);
    tick(); expect_v("t2 idle", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);
    // Pointer is now 3: REQ=1001 must pick channel 3, not channel 0.
    tick(); REQ = 4'b1001; LEN = 5'd2; done_q.push_back(4'b1000);
    expect_v("t3 ptr3 grant", ov(4'b1000, 5'd2, 1, 0, 0, 0), M_ALL);
    tick(); START = 0; expect_v("t3 cnt1", ov(4'b1000, 5'd1, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t3 done", ov(4'b1000, 5'd0, 0, 1, 0, 0), M_ALL);
    tick(); expect_v("t3 idle", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);

    // Pointer wrapped to 0. Drop REQ[1] for two cycles while CNT=2.
    tick(); START = 1; REQ = 4'b0110; LEN = 5'd3; done_q.push_back(4'b0010);
    expect_v("t4 cnt3", ov(4'b0010, 5'd3, 1, 0, 0, 0), M_ALL);
    tick(); START = 0; expect_v("t4 cnt2", ov(4'b0010, 5'd2, 1, 0, 0, 0), M_ALL);
    tick(); REQ = 4'b0100; expect_v("t4 hold1", ov(4'b0010, 5'd2, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t4 hold2", ov(4'b0010, 5'd2, 1, 0, 0, 0), M_ALL);
    tick(); REQ = 4'b0110; expect_v("t4 resume", ov(4'b0010, 5'd2, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t4 cnt1", ov(4'b0010, 5'd1, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t4 done", ov(4'b0010, 5'd0, 0, 1, 0, 0), M_ALL);
    tick(); expect_v("t4 idle", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);

    // Zero length sets the error state. Error is sticky against ABORT and START. CLR clears it.
    tick(); START = 1; REQ = 4'b0001; LEN = 5'd0;
    expect_v("len0 err", ov(4'b0000, 5'd0, 0, 0, 1, 1), M_ALL);
    tick(); ABORT = 1; LEN = 5'd3; expect_v("err abort held", ov(4'b0000, 5'd0, 0, 0, 1, 1), M_ALL);
    tick(); ABORT = 0; expect_v("err start held", ov(4'b0000, 5'd0, 0, 0, 1, 1), M_ALL);
    tick(); CLR = 1; START = 0; expect_v("clr from err", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);
    tick(); CLR = 0; ABORT = 1; expect_v("abort ignored idle", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);
    // ABORT during RUN goes to the error state and releases the grant.
    tick(); ABORT = 0; START = 1; REQ = 4'b0001; LEN = 5'd5;
    expect_v("t5 cnt5", ov(4'b0001, 5'd5, 1, 0, 0, 0), M_ALL);
    tick(); START = 0; ABORT = 1; expect_v("abort in run", ov(4'b0000, 5'd0, 0, 0, 1, 1), M_NOCNT);
    tick(); ABORT = 0; CLR = 1; expect_v("clr after abort", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);
    tick(); CLR = 0; REQ = '0;

    // Scan load of illegal state 5 with GNT=0100, then one functional edge returns to IDLE.
    for (int i = 0; i < 14; i++) begin
      tick(); SE = 1; SI = pat[13-i];
      if (i == 13) expect_v("scan load", ov(4'b0100, 5'd0, 0, 0, 0, 1), M_ALL);
      else         expect_v("scan so old", 13'h0000, M_SO);
    end
    tick(); SE = 0; SI = 0; expect_v("illegal to idle", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);
    // Shift the pattern in, then shift zeros: SO replays the pattern 14 shifts later.
    for (int i = 0; i < 28; i++) begin
      tick(); SE = 1; SI = (i < 14) ? pat[13-i] : 1'b0;
      expect_v("scan echo", {12'h000, ((i >= 13) && (i <= 26)) ? pat[26-i] : 1'b0}, M_SO);
    end
    tick(); SE = 0; expect_v("after scan", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);

    // Asynchronous reset between edges in the middle of RUN.
    tick(); START = 1; REQ = 4'b0001; LEN = 5'd4;
    expect_v("t6 cnt4", ov(4'b0001, 5'd4, 1, 0, 0, 0), M_ALL);
    tick(); START = 0; expect_v("t6 cnt3", ov(4'b0001, 5'd3, 1, 0, 0, 0), M_ALL);
    tick();
    #1 RSTN = 1'b0;
    #1 check("async reset", 32'({GNT, CNT, BUSY, DONE, ERR, SO}), 32'(0));
    tick(); RSTN = 1'b1; expect_v("idle after rst", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);
    // No transfer resumes after reset. A new start uses pointer 0.
    tick(); START = 1; REQ = 4'b0010; LEN = 5'd2; done_q.push_back(4'b0010);
    expect_v("t7 cnt2", ov(4'b0010, 5'd2, 1, 0, 0, 0), M_ALL);
    tick(); START = 0; expect_v("t7 cnt1", ov(4'b0010, 5'd1, 1, 0, 0, 0), M_ALL);
    tick(); expect_v("t7 done", ov(4'b0010, 5'd0, 0, 1, 0, 0), M_ALL);
    tick(); expect_v("t7 idle", ov(4'b0000, 5'd0, 0, 0, 0, 0), M_ALL);
    tick(); tick();

    check("done queue drained", 32'(done_q.size()), 32'(0));
    check("expect queue drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
